imem_load_ctrl: RTL and testbench

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_if.sv | 30 +++
 rtl/imem_load_ctrl.sv | 116 +++++++++++
 tb/tb_imem_load_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_if.sv
// imem_load_if: loader, processor-fetch and memory-port signals of imem_load_ctrl
interface imem_load_if;
    logic        load_req;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_hold;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic        load_done;
    logic [8:0]  word_count;
    logic        err_overflow;
    logic [31:0] checksum;

    modport master (
        output load_req, byte_valid, byte_data, cpu_pc, mem_rdata,
        input  byte_ready, cpu_instr, cpu_hold, mem_we, mem_waddr, mem_wdata,
               mem_raddr, load_done, word_count, err_overflow, checksum
    );
    modport slave (
        input  load_req, byte_valid, byte_data, cpu_pc, mem_rdata,
        output byte_ready, cpu_instr, cpu_hold, mem_we, mem_waddr, mem_wdata,
               mem_raddr, load_done, word_count, err_overflow, checksum
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: byte-stream loader for instruction memory, holds the CPU while loading.
// Define IMEM_LOAD_CHECKSUM_EN to accumulate an additive checksum of written words.
module imem_load_ctrl #(
    parameter int DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    imem_load_if.slave bus
);
    typedef enum logic [1:0] {RUN, LOAD, FLUSH, DONE} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [23:0] wbuf;
    logic [8:0]  wc;
    logic        err;
    logic        done_q;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;

    logic        full, acc, last;
    logic [1:0]  nidx;
    logic [23:0] nbuf;

    assign full = wc == 9'(DEPTH);
    assign acc  = state == LOAD && bus.byte_valid && !full;
    assign last = acc && idx == 2'd3;
    assign nidx = acc ? idx + 2'd1 : idx;
    // lower three bytes of the word being assembled, including this cycle's byte
    assign nbuf = acc ? wbuf | ({16'b0, bus.byte_data} << {idx, 3'b0}) : wbuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            idx    <= '0;
            wbuf   <= '0;
            wc     <= '0;
            err    <= 1'b0;
            done_q <= 1'b0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            we     <= 1'b0;
            done_q <= 1'b0;
            case (state)
                RUN: if (bus.load_req) begin
                    state <= LOAD;
                    wc    <= '0;
                    idx   <= '0;
                    wbuf  <= '0;
                    err   <= 1'b0;
                end
                LOAD: begin
                    idx <= nidx;
                    if (bus.byte_valid && full)
                        err <= 1'b1;
                    if (last) begin
                        we    <= 1'b1;
                        waddr <= wc[7:0];
                        wdata <= {bus.byte_data, wbuf};
                        wc    <= wc + 9'd1;
                        wbuf  <= '0;
                    end else begin
                        wbuf <= nbuf;
                    end
                    if (!bus.load_req) begin
                        if (nidx != 2'd0) begin
                            // partial word goes out during FLUSH, upper bytes already zero
                            state <= FLUSH;
                            we    <= 1'b1;
                            waddr <= wc[7:0];
                            wdata <= {8'h00, nbuf};
                            wc    <= wc + 9'd1;
                            wbuf  <= '0;
                            idx   <= '0;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] csum;
    always_ff @(posedge clk) begin
        if (reset || (state == RUN && bus.load_req))
            csum <= '0;
        else if (we)
            csum <= csum + wdata;
    end
    assign bus.checksum = csum;
`else
    assign bus.checksum = '0;
`endif

    assign bus.cpu_hold     = state != RUN;
    assign bus.byte_ready   = state == LOAD && !full;
    assign bus.mem_raddr    = bus.cpu_pc[9:2];
    assign bus.cpu_instr    = (state == RUN && {2'b00, bus.cpu_pc[31:2]} < 32'(DEPTH)) ? bus.mem_rdata : '0;
    assign bus.mem_we       = we;
    assign bus.mem_waddr    = waddr;
    assign bus.mem_wdata    = wdata;
    assign bus.load_done    = done_q;
    assign bus.word_count   = wc;
    assign bus.err_overflow = err;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: scoreboard bench driving a DEPTH=256 and a DEPTH=4 instance
module tb_imem_load_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_load_if i0();
    imem_load_if i1();

    imem_load_ctrl #(.DEPTH(256)) dut  (.clk(clk), .reset(reset), .bus(i0));
    imem_load_ctrl #(.DEPTH(4))   dut4 (.clk(clk), .reset(reset), .bus(i1));

    logic        req[2];
    logic        vld[2];
    logic [7:0]  dat[2];
    logic [31:0] pc;
    logic [31:0] mem0[256];
    logic [31:0] mem1[4];

    assign i0.load_req   = req[0];
    assign i1.load_req   = req[1];
    assign i0.byte_valid = vld[0];
    assign i1.byte_valid = vld[1];
    assign i0.byte_data  = dat[0];
    assign i1.byte_data  = dat[1];
    assign i0.cpu_pc     = pc;
    assign i1.cpu_pc     = pc;
    assign i0.mem_rdata  = mem0[i0.mem_raddr];
    assign i1.mem_rdata  = mem1[i1.mem_raddr[1:0]];

    logic        rdy[2], done[2], hold[2], err[2];
    logic [8:0]  wc[2];
    logic [31:0] csum[2];
    assign rdy[0]  = i0.byte_ready;
    assign rdy[1]  = i1.byte_ready;
    assign done[0] = i0.load_done;
    assign done[1] = i1.load_done;
    assign hold[0] = i0.cpu_hold;
    assign hold[1] = i1.cpu_hold;
    assign err[0]  = i0.err_overflow;
    assign err[1]  = i1.err_overflow;
    assign wc[0]   = i0.word_count;
    assign wc[1]   = i1.word_count;
    assign csum[0] = i0.checksum;
    assign csum[1] = i1.checksum;

    // memory models; two locations are preloaded so fetch reads are distinguishable
    always @(posedge clk) begin
        if (reset) begin
            mem0[2]   <= 32'hCAFEF00D;
            mem0[255] <= 32'h13579BDF;
        end else if (i0.mem_we)
            mem0[i0.mem_waddr] <= i0.mem_wdata;
        if (i1.mem_we)
            mem1[i1.mem_waddr[1:0]] <= i1.mem_wdata;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [39:0] exq0[$];
    logic [39:0] exq1[$];
    int          midx[2];
    logic [31:0] mword[2];
    int          mcnt[2];
    logic [31:0] msum[2];
    int          wrcnt[2];

    task automatic push_word(input int d);
        logic [39:0] e;
        e = {mcnt[d][7:0], mword[d]};
        if (d == 0) exq0.push_back(e);
        else exq1.push_back(e);
        msum[d] += mword[d];
        mcnt[d]++;
        mword[d] = '0;
        midx[d]  = 0;
    endtask

    task automatic model_byte(input int d, input logic [7:0] b);
        mword[d][8*midx[d] +: 8] = b;
        midx[d]++;
        if (midx[d] == 4) push_word(d);
    endtask

    always @(negedge clk) begin : mon
        logic [39:0] e;
        if (i0.mem_we) begin
            wrcnt[0]++;
            if (exq0.size() == 0) check("wr0_unexpected", 32'd1, 32'd0);
            else begin
                e = exq0.pop_front();
                check("wr0_addr", 32'(i0.mem_waddr), 32'(e[39:32]));
                check("wr0_data", i0.mem_wdata, e[31:0]);
            end
        end
        if (i1.mem_we) begin
            wrcnt[1]++;
            if (exq1.size() == 0) check("wr1_unexpected", 32'd1, 32'd0);
            else begin
                e = exq1.pop_front();
                check("wr1_addr", 32'(i1.mem_waddr), 32'(e[39:32]));
                check("wr1_data", i1.mem_wdata, e[31:0]);
            end
        end
    end

    task automatic start_load(input int d);
        @(negedge clk);
        req[d]   = 1'b1;
        midx[d]  = 0;
        mword[d] = '0;
        mcnt[d]  = 0;
        msum[d]  = '0;
        wrcnt[d] = 0;
        @(negedge clk);
        check("hold_in_load", 32'(hold[d]), 32'd1);
    endtask

    task automatic send(input int d, input logic [7:0] b, input bit drop);
        int n = 0;
        @(negedge clk);
        vld[d] = 1'b1;
        dat[d] = b;
        if (drop) req[d] = 1'b0;
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("byte_ready_timeout", 32'(rdy[d]), 32'd1);
            vld[d] = 1'b0;
            return;
        end
        @(posedge clk);
        model_byte(d, b);
        #1 vld[d] = 1'b0;
    endtask

    task automatic end_load(input int d);
        int lat;
        int n = 0;
        logic [31:0] exp_sum;
        @(negedge clk);
        lat = req[d] ? (midx[d] != 0 ? 2 : 1) : 0;
        if (midx[d] != 0) push_word(d);
        req[d] = 1'b0;
        while (!done[d] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", 32'(n), 32'(lat));
        check("word_count", 32'(wc[d]), 32'(mcnt[d]));
        @(negedge clk);
        check("done_pulse", 32'(done[d]), 32'd0);
        check("hold_release", 32'(hold[d]), 32'd0);
        check("write_count", 32'(wrcnt[d]), 32'(mcnt[d]));
`ifdef IMEM_LOAD_CHECKSUM_EN
        exp_sum = msum[d];
`else
        exp_sum = '0;
`endif
        check("checksum", csum[d], exp_sum);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        pc = a;
        #1;
        check("fetch_raddr", 32'(i0.mem_raddr), 32'(a[9:2]));
        check("fetch_instr", i0.cpu_instr, exp);
    endtask

    initial begin
        logic [7:0] t1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        logic [7:0] t2 [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        logic [7:0] t3 [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        req = '{1'b0, 1'b0};
        vld = '{1'b0, 1'b0};
        dat = '{8'h00, 8'h00};
        pc  = '0;
        repeat (2) @(negedge clk);
        check("rst_hold", 32'(hold[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]), 32'd0);
        check("rst_we", 32'(i0.mem_we), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_wc", 32'(wc[0]), 32'd0);
        check("rst_csum", csum[0], 32'd0);
        check("rst_waddr", 32'(i0.mem_waddr), 32'd0);
        check("rst_wdata", i0.mem_wdata, 32'd0);
        check("rst_hold4", 32'(hold[1]), 32'd0);
        reset = 1'b0;

        start_load(0);
        pc = 32'h8;
        #1 check("instr_held", i0.cpu_instr, 32'd0);
        foreach (t1[i]) send(0, t1[i], 1'b0);
        end_load(0);

        start_load(0);
        foreach (t2[i]) send(0, t2[i], 1'b0);
        end_load(0);

        start_load(0);
        foreach (t3[i]) send(0, t3[i], i == 3);
        end_load(0);

        fetch(32'h0000_0008, 32'hCAFEF00D);
        fetch(32'h0000_000B, 32'hCAFEF00D);
        fetch(32'h0000_03FC, 32'h13579BDF);
        fetch(32'h0000_0400, 32'h0);
        fetch(32'h0000_0004, 32'h000000AA);
        fetch(32'h0000_0000, 32'hAABBCCDD);

        start_load(1);
        for (int i = 0; i < 16; i++) send(1, 8'(i * 3 + 1), 1'b0);
        @(negedge clk);
        check("full_ready", 32'(rdy[1]), 32'd0);
        check("full_wc", 32'(wc[1]), 32'd4);
        check("err_before", 32'(err[1]), 32'd0);
        vld[1] = 1'b1;
        dat[1] = 8'h55;
        @(negedge clk);
        check("err_set", 32'(err[1]), 32'd1);
        vld[1] = 1'b0;
        end_load(1);
        check("err_sticky", 32'(err[1]), 32'd1);
        start_load(1);
        check("err_cleared", 32'(err[1]), 32'd0);
        end_load(1);

        start_load(0);
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        req[0]   = 1'b0;
        midx[0]  = 0;
        mword[0] = '0;
        @(negedge clk);
        check("midrst_hold", 32'(hold[0]), 32'd0);
        check("midrst_ready", 32'(rdy[0]), 32'd0);
        check("midrst_we", 32'(i0.mem_we), 32'd0);
        check("midrst_wc", 32'(wc[0]), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        fetch(32'h0000_0000, 32'hAABBCCDD);

        check("queue0_empty", 32'(exq0.size()), 32'd0);
        check("queue1_empty", 32'(exq1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
